// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and constants
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DROP  = 3'd3,
        ST_HOLD  = 3'd4
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

    function automatic logic tgt_misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry skid register for a stalled fetch response
module fetch_skid #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;

    // Clear wins over load so a redirect can never leave a stale entry behind.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear) begin
            valid_d = 1'b0;
            pc_d    = '0;
            instr_d = '0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = pc_in;
            instr_d = instr_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with redirect, drop and hazard hold
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int            XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] current_pc,
    output logic [XLEN-1:0] next_pc,
    output logic            pc_stall,
    input  logic            hz_stall,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            flush_ifid,
    output logic            misalign
);

    localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

    fetch_state_e    state_q, state_d;
    logic            active;
    logic            redirect;
    logic [XLEN-1:0] redir_tgt;
    logic            wait_rsp;
    logic            consume;
    logic            skid_load;
    logic            skid_clear;
    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_instr;

    fetch_skid #(.XLEN(XLEN)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .clear    (skid_clear),
        .pc_in    (current_pc),
        .instr_in (imem_rdata),
        .valid    (skid_valid),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );

    // Redirects are ignored while in reset or the post-reset IDLE cycle.
    always_comb begin
        active    = !rst && (state_q != ST_IDLE);
        redirect  = active && (trap || br_taken);
        redir_tgt = trap ? trap_vec : br_target;
        misalign  = active && ((trap && tgt_misaligned(trap_vec[1:0])) ||
                               (br_taken && tgt_misaligned(br_target[1:0])));
        wait_rsp  = (state_q == ST_WAIT) && imem_rvalid;
        consume   = !redirect && !hz_stall &&
                    (wait_rsp || (state_q == ST_HOLD && skid_valid));
        skid_load  = !redirect && wait_rsp && hz_stall;
        skid_clear = (redirect && (state_q == ST_HOLD || state_q == ST_FETCH)) ||
                     ((state_q == ST_HOLD) && consume);

        imem_req   = !rst && (state_q == ST_FETCH);
        imem_addr  = imem_req ? current_pc : '0;
        flush_ifid = redirect;
        pc_stall   = !(redirect || consume);

        if (!active)
            next_pc = RESET_PC;
        else if (redirect)
            next_pc = redir_tgt;
        else
            next_pc = current_pc + XLEN'(INSTR_BYTES);
    end

    // The PC is held through FETCH and WAIT, so current_pc still names the word in flight.
    always_comb begin
        if_valid = 1'b0;
        if_pc    = '0;
        if_instr = NOP;
        if (!active) begin
            if_instr = '0;
        end else if (!redirect) begin
            if (wait_rsp && !hz_stall) begin
                if_valid = 1'b1;
                if_pc    = current_pc;
                if_instr = imem_rdata;
            end else if (state_q == ST_HOLD && skid_valid) begin
                if_valid = 1'b1;
                if_pc    = skid_pc;
                if_instr = skid_instr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                // An accepted request in a redirect cycle still has a response coming.
                if (imem_ready)
                    state_d = redirect ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect)
                    state_d = imem_rvalid ? ST_FETCH : ST_DROP;
                else if (imem_rvalid)
                    state_d = hz_stall ? ST_HOLD : ST_FETCH;
            end
            ST_DROP: begin
                if (imem_rvalid)
                    state_d = ST_FETCH;
            end
            ST_HOLD: begin
                if (redirect || !hz_stall)
                    state_d = ST_FETCH;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector bench for fetch_ctrl
module tb_fetch_ctrl;

    localparam logic [31:0] N = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] current_pc;
    logic [31:0] next_pc;
    logic        pc_stall;
    logic        hz_stall;
    logic        trap;
    logic [31:0] trap_vec;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush_ifid;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .current_pc  (current_pc),
        .next_pc     (next_pc),
        .pc_stall    (pc_stall),
        .hz_stall    (hz_stall),
        .trap        (trap),
        .trap_vec    (trap_vec),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .flush_ifid  (flush_ifid),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        hz;
        logic        tr;
        logic [31:0] tv;
        logic        br;
        logic [31:0] bt;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_npc;
        logic        e_stall;
        logic        e_ifv;
        logic [31:0] e_ifpc;
        logic [31:0] e_ifi;
        logic        e_flush;
        logic        e_mis;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic r, input logic [31:0] pc, input logic hz, input logic tr,
        input logic [31:0] tv, input logic br, input logic [31:0] bt,
        input logic rdy, input logic rv, input logic [31:0] rd,
        input logic ereq, input logic [31:0] eaddr, input logic [31:0] enpc,
        input logic estall, input logic eifv, input logic [31:0] eifpc,
        input logic [31:0] eifi, input logic eflush, input logic emis);
        vec_t v;
        v.rst = r;  v.pc = pc;  v.hz = hz;  v.tr = tr;  v.tv = tv;
        v.br = br;  v.bt = bt;  v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_req = ereq;   v.e_addr = eaddr; v.e_npc = enpc; v.e_stall = estall;
        v.e_ifv = eifv;   v.e_ifpc = eifpc; v.e_ifi = eifi;
        v.e_flush = eflush; v.e_mis = emis;
        return v;
    endfunction

    task automatic chk1(input string nm, input int row, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %b want %b", nm, row, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b1; current_pc = '0; hz_stall = 1'b0; trap = 1'b0; trap_vec = '0;
        br_taken = 1'b0; br_target = '0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        //             rst pc            hz tr tv        br bt        rdy rv rd             req addr          npc           st ifv ifpc          ifi            fl mis
        vq.push_back(mk(1, 32'h0,        0, 1, 32'h80,  0, 32'h0,   1, 1, 32'h1111,      0, 32'h0,        32'h0,        1, 0, 32'h0,        32'h0,        0, 0));
        vq.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         0, 32'h0,        32'h0,        1, 0, 32'h0,        32'h0,        0, 0));
        vq.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         1, 32'h0,        32'h4,        1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         0, 32'h0,        32'h4,        1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 1, 32'hAAAA0001,  0, 32'h0,        32'h4,        0, 1, 32'h0,        32'hAAAA0001, 0, 0));
        vq.push_back(mk(0, 32'h4,        0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         1, 32'h4,        32'h8,        1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h4,        0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         0, 32'h0,        32'h8,        1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h4,        0, 0, 32'h0,   0, 32'h0,   1, 1, 32'hBBBB0002,  0, 32'h0,        32'h8,        0, 1, 32'h4,        32'hBBBB0002, 0, 0));
        vq.push_back(mk(0, 32'h8,        0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         1, 32'h8,        32'hC,        1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h8,        1, 0, 32'h0,   0, 32'h0,   1, 1, 32'hCCCC0003,  0, 32'h0,        32'hC,        1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h8,        1, 0, 32'h0,   0, 32'h0,   1, 0, 32'hDEAD0000,  0, 32'h0,        32'hC,        1, 1, 32'h8,        32'hCCCC0003, 0, 0));
        vq.push_back(mk(0, 32'h8,        1, 0, 32'h0,   0, 32'h0,   1, 1, 32'hDEAD0001,  0, 32'h0,        32'hC,        1, 1, 32'h8,        32'hCCCC0003, 0, 0));
        vq.push_back(mk(0, 32'h8,        0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         0, 32'h0,        32'hC,        0, 1, 32'h8,        32'hCCCC0003, 0, 0));
        vq.push_back(mk(0, 32'hC,        0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         1, 32'hC,        32'h10,       1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'hC,        0, 0, 32'h0,   1, 32'h100, 1, 0, 32'h0,         0, 32'h0,        32'h100,      0, 0, 32'h0,        N,            1, 0));
        vq.push_back(mk(0, 32'h100,      0, 0, 32'h0,   0, 32'h0,   1, 1, 32'hEEEE0000,  0, 32'h0,        32'h104,      1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h100,      0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         1, 32'h100,      32'h104,      1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h100,      0, 1, 32'h80,  1, 32'h200, 1, 0, 32'h0,         0, 32'h0,        32'h80,       0, 0, 32'h0,        N,            1, 0));
        vq.push_back(mk(0, 32'h80,       0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         0, 32'h0,        32'h84,       1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h80,       0, 0, 32'h0,   0, 32'h0,   1, 1, 32'hFFFF0000,  0, 32'h0,        32'h84,       1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h80,       0, 0, 32'h0,   1, 32'h102, 0, 0, 32'h0,         1, 32'h80,       32'h102,      0, 0, 32'h0,        N,            1, 1));
        vq.push_back(mk(0, 32'h102,      0, 0, 32'h0,   1, 32'h40,  1, 0, 32'h0,         1, 32'h102,      32'h40,       0, 0, 32'h0,        N,            1, 0));
        vq.push_back(mk(0, 32'h40,       0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h77770000,  0, 32'h0,        32'h44,       1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h40,       0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         1, 32'h40,       32'h44,       1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h40,       0, 0, 32'h0,   1, 32'h300, 1, 1, 32'h44440000,  0, 32'h0,        32'h300,      0, 0, 32'h0,        N,            1, 0));
        vq.push_back(mk(0, 32'h300,      0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         1, 32'h300,      32'h304,      1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h300,      1, 0, 32'h0,   0, 32'h0,   1, 1, 32'h12340000,  0, 32'h0,        32'h304,      1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'h300,      1, 1, 32'h6,   0, 32'h0,   1, 0, 32'h0,         0, 32'h0,        32'h6,        0, 0, 32'h0,        N,            1, 1));
        vq.push_back(mk(0, 32'h6,        1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,         1, 32'h6,        32'hA,        1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'hFFFFFFFC, 0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         1, 32'hFFFFFFFC, 32'h0,        1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(0, 32'hFFFFFFFC, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h5555AAAA,  0, 32'h0,        32'h0,        0, 1, 32'hFFFFFFFC, 32'h5555AAAA, 0, 0));
        vq.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         1, 32'h0,        32'h4,        1, 0, 32'h0,        N,            0, 0));
        vq.push_back(mk(1, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         0, 32'h0,        32'h0,        1, 0, 32'h0,        32'h0,        0, 0));
        vq.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h99990000,  0, 32'h0,        32'h0,        1, 0, 32'h0,        32'h0,        0, 0));
        vq.push_back(mk(0, 32'h0,        0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,         1, 32'h0,        32'h4,        1, 0, 32'h0,        N,            0, 0));

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; current_pc = vq[i].pc; hz_stall = vq[i].hz;
            trap = vq[i].tr; trap_vec = vq[i].tv; br_taken = vq[i].br; br_target = vq[i].bt;
            imem_ready = vq[i].rdy; imem_rvalid = vq[i].rv; imem_rdata = vq[i].rd;
            #2;
            chk1 ("imem_req",   i, imem_req,   vq[i].e_req);
            chk32("imem_addr",  i, imem_addr,  vq[i].e_addr);
            chk32("next_pc",    i, next_pc,    vq[i].e_npc);
            chk1 ("pc_stall",   i, pc_stall,   vq[i].e_stall);
            chk1 ("if_valid",   i, if_valid,   vq[i].e_ifv);
            chk32("if_pc",      i, if_pc,      vq[i].e_ifpc);
            chk32("if_instr",   i, if_instr,   vq[i].e_ifi);
            chk1 ("flush_ifid", i, flush_ifid, vq[i].e_flush);
            chk1 ("misalign",   i, misalign,   vq[i].e_mis);
        end

        // Reset asserted between edges while in HOLD must act immediately.
        @(negedge clk);
        trap = 1'b0; br_taken = 1'b0; imem_ready = 1'b0;
        imem_rvalid = 1'b1; hz_stall = 1'b1; imem_rdata = 32'hABCD0001; current_pc = 32'h0;
        #2;
        chk1("seq_wait_hz_stall", 100, pc_stall, 1'b1);
        @(negedge clk);
        imem_rvalid = 1'b0;
        #2;
        chk1 ("seq_hold_valid", 101, if_valid, 1'b1);
        chk32("seq_hold_instr", 101, if_instr, 32'hABCD0001);
        #1 rst = 1'b1;
        #1;
        chk1 ("seq_async_valid", 102, if_valid, 1'b0);
        chk1 ("seq_async_req",   102, imem_req, 1'b0);
        chk1 ("seq_async_stall", 102, pc_stall, 1'b1);
        chk32("seq_async_instr", 102, if_instr, 32'h0);

        @(negedge clk);
        rst = 1'b0; hz_stall = 1'b0; imem_ready = 1'b1;
        #2;
        chk1("seq_idle_req", 103, imem_req, 1'b0);
        cnt = 1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #2;
            cnt++;
            if (imem_req) break;
        end
        chk32("seq_first_req_cycle", 104, 32'(cnt), 32'd2);
        chk32("seq_restart_addr",    104, imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
